alu_muldiv_unit: RTL and testbench

Parametrised successor to the combinational integer ALU. It adds signed/unsigned compares, full RV32M multiply/divide/remainder and a valid/ready handshake.
- Base ops produce a registered result 1 cycle after acceptance.
- MUL/DIV-class ops run on an iterative shift-add / restoring-divide datapath.
- Sits in the execute stage between the operand muxes and the writeback/branch logic.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_muldiv_unit_serial_muldiv.sv | 116 +++++++++++
 rtl/alu_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the execute-stage ALU with RV32M multiply/divide.
//   alu_op_e  - 5-bit operation select codes (base ops 0-11, M ops 16-23)
//   state_e   - control FSM states of alu_muldiv_unit
//   is_muldiv - true for ops executed on the serial multiply/divide datapath
//   is_div    - true for the divide/remainder subset of the M ops
package alu_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_AND    = 5'd2,
      ALU_OR     = 5'd3,
      ALU_SLL    = 5'd4,
      ALU_SLT    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_SGE    = 5'd8,
      ALU_XOR    = 5'd9,
      ALU_SLTU   = 5'd10,
      ALU_SGEU   = 5'd11,
      ALU_MUL    = 5'd16,
      ALU_MULH   = 5'd17,
      ALU_MULHSU = 5'd18,
      ALU_MULHU  = 5'd19,
      ALU_DIV    = 5'd20,
      ALU_DIVU   = 5'd21,
      ALU_REM    = 5'd22,
      ALU_REMU   = 5'd23
   } alu_op_e;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   function automatic logic is_muldiv(input alu_op_e op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

   function automatic logic is_div(input alu_op_e op);
      return (op >= ALU_DIV) && (op <= ALU_REMU);
   endfunction

endpackage

// File: rtl/alu_muldiv_unit_serial_muldiv.sv
// serial_muldiv: iterative shift-add multiplier / restoring divider.
//   clk, rst_n     - clock, synchronous active-low reset
//   abort          - drop any operation in progress
//   start          - load operands and begin (ignored while abort is high)
//   a_signed/b_signed - treat a/b as two's complement
//   div_mode       - 1: divide a by b, 0: multiply a by b
//   a, b           - operands
//   done           - high during the last of XLEN iteration cycles; the
//                    result outputs are valid in that same cycle
//   product        - 2*XLEN signed/unsigned product
//   quotient, remainder - divide results (remainder signed like a)
// Divide by zero and signed overflow are never started here.
module serial_muldiv #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            abort,
   input  logic            start,
   input  logic            a_signed,
   input  logic            b_signed,
   input  logic            div_mode,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [2*XLEN-1:0] product,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   logic            busy;
   logic [CNT_W-1:0] cnt;
   logic            mode_div;
   logic            neg_res;   // product / quotient negative
   logic            neg_rem;   // remainder negative (follows dividend)
   logic [XLEN-1:0] hi;        // partial product high half / partial remainder
   logic [XLEN-1:0] lo;        // multiplier / dividend shifting into quotient
   logic [XLEN-1:0] opb;       // multiplicand / divisor magnitude

   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN+1:0] diff;
   logic [XLEN-1:0] hi_n, lo_n;
   logic [2*XLEN-1:0] prod_mag;

   assign a_neg = a_signed & a[XLEN-1];
   assign b_neg = b_signed & b[XLEN-1];
   assign a_mag = a_neg ? (~a + 1'b1) : a;
   assign b_mag = b_neg ? (~b + 1'b1) : b;

   // One iteration step; results are taken from the step outputs so the
   // final answer is available in the last iteration cycle itself.
   always_comb begin
      sum    = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      rem_sh = {hi, lo[XLEN-1]};
      diff   = {1'b0, rem_sh} - {2'b00, opb};
      hi_n   = hi;
      lo_n   = lo;
      if (mode_div) begin
         if (!diff[XLEN+1]) begin
            hi_n = diff[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b1};
         end else begin
            hi_n = rem_sh[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo[XLEN-1:1]};
      end
   end

   assign prod_mag  = {hi_n, lo_n};
   assign product   = neg_res ? (~prod_mag + 1'b1) : prod_mag;
   assign quotient  = neg_res ? (~lo_n + 1'b1) : lo_n;
   assign remainder = neg_rem ? (~hi_n + 1'b1) : hi_n;
   assign done      = busy && (cnt == CNT_W'(XLEN-1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         cnt      <= '0;
         mode_div <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         opb      <= '0;
      end else if (abort) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         cnt      <= '0;
         mode_div <= div_mode;
         neg_res  <= a_neg ^ b_neg;
         neg_rem  <= a_neg;
         hi       <= '0;
         lo       <= a_mag;
         opb      <= b_mag;
      end else if (busy) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
            cnt  <= '0;
         end
      end
   end

endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: execute-stage integer ALU with RV32M mul/div and a
// valid/ready handshake. Base ops and divide special cases answer one cycle
// after acceptance; other M ops take XLEN+1 cycles on serial_muldiv.
//   clk, rst_n         - clock, synchronous active-low reset
//   flush              - abort in-flight or held result (beats accept)
//   in_valid/in_ready  - request handshake
//   op1, op2, ALU_ctrl - operands and operation select (alu_op_e)
//   out_valid/out_ready - result handshake
//   ALUout             - registered result
//   eq, lt, ltu        - operand compares captured at acceptance
module alu_muldiv_unit
   import alu_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic [4:0]      ALU_ctrl,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUout,
   output logic            eq,
   output logic            lt,
   output logic            ltu
);

   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state;
   alu_op_e         op, op_q;
   logic            accept;
   logic            eq_c, lt_c, ltu_c;
   logic            special;
   logic            md_start, md_a_signed, md_b_signed, md_done;
   logic [XLEN-1:0] imm_result, md_result;
   logic [2*XLEN-1:0] md_product;
   logic [XLEN-1:0] md_quotient, md_remainder;
   logic [SHAMT_W-1:0] shamt;

   assign op     = alu_op_e'(ALU_ctrl);
   assign shamt  = op2[SHAMT_W-1:0];
   assign eq_c   = (op1 == op2);
   assign lt_c   = ($signed(op1) < $signed(op2));
   assign ltu_c  = (op1 < op2);

   assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept   = in_valid && in_ready && !flush;

   // Single-cycle result: base ops, undefined codes, divide special cases.
   always_comb begin
      special    = 1'b0;
      imm_result = '0;
      if (is_div(op) && (op2 == '0)) begin
         special    = 1'b1;
         imm_result = ((op == ALU_DIV) || (op == ALU_DIVU)) ? '1 : op1;
      end else if (((op == ALU_DIV) || (op == ALU_REM)) &&
                   (op1 == MIN_VAL) && (op2 == '1)) begin
         special    = 1'b1;
         imm_result = (op == ALU_DIV) ? MIN_VAL : '0;
      end else begin
         case (op)
            ALU_ADD:  imm_result = op1 + op2;
            ALU_SUB:  imm_result = op1 - op2;
            ALU_AND:  imm_result = op1 & op2;
            ALU_OR:   imm_result = op1 | op2;
            ALU_SLL:  imm_result = op1 << shamt;
            ALU_SLT:  imm_result = XLEN'(lt_c);
            ALU_SRL:  imm_result = op1 >> shamt;
            ALU_SRA:  imm_result = $unsigned($signed(op1) >>> shamt);
            ALU_SGE:  imm_result = XLEN'(!lt_c);
            ALU_XOR:  imm_result = op1 ^ op2;
            ALU_SLTU: imm_result = XLEN'(ltu_c);
            ALU_SGEU: imm_result = XLEN'(!ltu_c);
            default:  imm_result = '0;
         endcase
      end
   end

   assign md_start    = accept && is_muldiv(op) && !special;
   assign md_a_signed = (op == ALU_MULH) || (op == ALU_MULHSU) ||
                        (op == ALU_DIV)  || (op == ALU_REM);
   assign md_b_signed = (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);

   serial_muldiv #(.XLEN(XLEN)) u_muldiv (
      .clk       (clk),
      .rst_n     (rst_n),
      .abort     (flush),
      .start     (md_start),
      .a_signed  (md_a_signed),
      .b_signed  (md_b_signed),
      .div_mode  (is_div(op)),
      .a         (op1),
      .b         (op2),
      .done      (md_done),
      .product   (md_product),
      .quotient  (md_quotient),
      .remainder (md_remainder)
   );

   always_comb begin
      case (op_q)
         ALU_MUL:                          md_result = md_product[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU:  md_result = md_product[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:                md_result = md_quotient;
         default:                          md_result = md_remainder;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= ALU_ADD;
         out_valid <= 1'b0;
         ALUout    <= '0;
         eq        <= 1'b0;
         lt        <= 1'b0;
         ltu       <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  op_q <= op;
                  eq   <= eq_c;
                  lt   <= lt_c;
                  ltu  <= ltu_c;
                  if (md_start) begin
                     state     <= CALC;
                     out_valid <= 1'b0;
                  end else begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     ALUout    <= imm_result;
                  end
               end else if ((state == DONE) && out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            CALC: begin
               if (md_done) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  ALUout    <= md_result;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed self-checking bench for alu_muldiv_unit
// (XLEN=32) using hand-computed expected values.
module tb_alu_muldiv_unit;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic        eq, lt, ltu;
   logic [31:0] op1, op2, ALUout;
   logic [4:0]  ALU_ctrl;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op1       (op1),
      .op2       (op2),
      .ALU_ctrl  (ALU_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUout    (ALUout),
      .eq        (eq),
      .lt        (lt),
      .ltu       (ltu)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      ALU_ctrl = op;
      op1      = a;
      op2      = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   // Single-cycle op: result must be valid right after the accepting edge.
   task automatic base(input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      issue(op, a, b);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk(tag, ALUout, exp);
   endtask

   // Serial op: expects out_valid exactly 33 cycles after accept; operand
   // inputs are scrambled and in_valid held high while it computes.
   task automatic run_md(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int n;
      out_ready = 1'b1;
      issue(op, a, b);
      chk({tag, "_busy_ready"}, {31'b0, in_ready}, 32'd0);
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
         op1      = $urandom;
         op2      = $urandom;
         ALU_ctrl = 5'd0;
         in_valid = 1'b1;
         step();
         n++;
      end
      in_valid = 1'b0;
      chk({tag, "_latency"}, 32'(n + 1), 32'd33);
      chk(tag, ALUout, exp);
      step();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op1 = '0; op2 = '0; ALU_ctrl = '0;
      step(); step();
      rst_n = 1'b1;
      step();
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out",   ALUout, 32'd0);
      chk("rst_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_flags", {29'b0, eq, lt, ltu}, 32'd0);

      // Base ops issued back-to-back with out_ready held high
      base("sub", 5'd1, 32'd5, 32'd5, 32'd0);
      chk("sub_eq", {31'b0, eq}, 32'd1);
      base("slt", 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd1);
      chk("slt_flags", {29'b0, eq, lt, ltu}, 32'b010);
      base("add_wrap",  5'd0,  32'hFFFF_FFFF, 32'd2, 32'd1);
      base("add_ovf",   5'd0,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
      base("and",       5'd2,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
      base("or",        5'd3,  32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF);
      base("sll_mask",  5'd4,  32'd1, 32'd33, 32'd2);
      base("srl",       5'd6,  32'h8000_0000, 32'd4, 32'h0800_0000);
      base("sra",       5'd7,  32'h8000_0000, 32'd4, 32'hF800_0000);
      base("sge_neg",   5'd8,  32'hFFFF_FFFF, 32'd1, 32'd0);
      base("sge_eq",    5'd8,  32'd5, 32'd5, 32'd1);
      base("xor",       5'd9,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
      base("sltu",      5'd10, 32'hFFFF_FFFF, 32'd1, 32'd0);
      base("sgeu",      5'd11, 32'hFFFF_FFFF, 32'd1, 32'd1);
      chk("sgeu_flags", {29'b0, eq, lt, ltu}, 32'b010);
      base("undef",     5'd12, 32'd3, 32'd3, 32'd0);
      chk("undef_flags", {29'b0, eq, lt, ltu}, 32'b100);
      step();
      chk("drain_valid", {31'b0, out_valid}, 32'd0);

      // Serial multiply / divide
      run_md("mulhu",  5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_md("mul",    5'd16, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      run_md("mulh",   5'd17, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
      run_md("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
      run_md("div",    5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_md("rem",    5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_md("divu",   5'd21, 32'd100, 32'd7, 32'd14);
      run_md("remu",   5'd23, 32'd100, 32'd7, 32'd2);

      // Divide special cases complete in one cycle
      base("divu_by0", 5'd21, 32'd10, 32'd0, 32'hFFFF_FFFF);
      base("remu_by0", 5'd23, 32'd10, 32'd0, 32'd10);
      base("div_ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      base("rem_ovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      step();

      // Backpressure then back-to-back accept
      out_ready = 1'b0;
      base("bp_add", 5'd0, 32'd10, 32'd20, 32'd30);
      for (int i = 0; i < 4; i++) begin
         op1 = $urandom;
         step();
         chk("bp_hold",  ALUout, 32'd30);
         chk("bp_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_ready", {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      ALU_ctrl = 5'd3; op1 = 32'hF0; op2 = 32'h0F; in_valid = 1'b1;
      #1;
      chk("b2b_ready", {31'b0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b_or", ALUout, 32'hFF);
      step();
      chk("b2b_drain", {31'b0, out_valid}, 32'd0);

      // Flush in the 10th CALC cycle of a DIVU
      issue(5'd21, 32'd1000, 32'd3);
      for (int i = 0; i < 9; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_ready", {31'b0, in_ready}, 32'd1);
      chk("flush_keep",  ALUout, 32'hFF);
      for (int i = 0; i < 40; i++) step();
      chk("flush_quiet", {31'b0, out_valid}, 32'd0);
      base("flush_add", 5'd0, 32'd2, 32'd3, 32'd5);
      step();

      // flush wins over a simultaneous request
      ALU_ctrl = 5'd0; op1 = 32'd1; op2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      chk("flush_prio_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_prio_out",   ALUout, 32'd5);

      // Reset in the middle of a multiply
      issue(5'd16, 32'd9, 32'd9);
      step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("midrst_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_out",   ALUout, 32'd0);
      for (int i = 0; i < 40; i++) step();
      chk("midrst_quiet", {31'b0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
